// File: rtl/wvb_reader_pkg.sv
// Shared definitions for the waveform buffer reader: FSM encoding and channel index width.
package wvb_reader_pkg;

  localparam int unsigned CHAN_IDX_W = 5;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_HDR_WAIT    = 3'd1,
    S_RD_CTRL_REQ = 3'd2,
    S_DPRAM_RUN   = 3'd3,
    S_DPRAM_BUSY  = 3'd4,
    S_DPRAM_DONE  = 3'd5
  } fsm_t;

endpackage

// File: rtl/n_channel_mux.sv
// Combinational N-way word mux; selects word 'sel' from a packed vector, zero if out of range.
module n_channel_mux #(
  parameter int unsigned N_INPUTS = 24,
  parameter int unsigned W        = 80,
  parameter int unsigned SEL_W    = 5
) (
  input  logic [N_INPUTS*W-1:0] data,
  input  logic [SEL_W-1:0]      sel,
  output logic [W-1:0]          out
);

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (32'(sel) == i) out = data[i*W +: W];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Masked rotating-priority grant finder: first request above 'last', wrapping, 'last' checked last.
module rr_arbiter
  import wvb_reader_pkg::*;
#(
  parameter int unsigned N = 24
) (
  input  logic [N-1:0]          req,
  input  logic [CHAN_IDX_W-1:0] last,
  output logic [CHAN_IDX_W-1:0] grant,
  output logic                  valid
);

  // Two ascending passes replace a modulo walk: channels above 'last', then 0..last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[i] && (i > 32'(last))) begin
        valid = 1'b1;
        grant = CHAN_IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[i] && (i <= 32'(last))) begin
        valid = 1'b1;
        grant = CHAN_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wvb_reader_arb.sv
// Multi-channel waveform buffer reader: round-robin channel select, data mux, DPRAM run/busy sequencing.
// Optional busy-wait watchdog enabled by defining WVB_RDR_TIMEOUT_EN.
module wvb_reader_arb
  import wvb_reader_pkg::*;
#(
  parameter int unsigned N_CHANNELS   = 24,
  parameter int unsigned P_DATA_WIDTH = 85,
  parameter int unsigned P_HDR_WIDTH  = 80,
  parameter int unsigned P_HDR_WT_CNT = 3,
  parameter int unsigned P_CNT_WIDTH  = 32,
  parameter int unsigned P_TIMEOUT    = 65535
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [N_CHANNELS-1:0]              chan_mask,
  input  logic [N_CHANNELS-1:0]              hdr_empty,
  input  logic [N_CHANNELS*P_HDR_WIDTH-1:0]  hdr_data,
  input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data,
  output logic [N_CHANNELS-1:0]              hdr_rdreq,
  output logic [N_CHANNELS-1:0]              wvb_rdreq,
  output logic [N_CHANNELS-1:0]              wvb_rddone,
  output logic                               rd_req,
  input  logic                               rd_ack,
  input  logic                               rd_more,
  input  logic [15:0]                        rd_len,
  input  logic                               rd_wvb_rdreq,
  input  logic                               rd_wvb_rddone,
  output logic [P_HDR_WIDTH-1:0]             rd_hdr_data,
  output logic [P_DATA_WIDTH-1:0]            rd_wvb_data,
  input  logic                               dpram_busy,
  input  logic                               dpram_mode,
  output logic                               dpram_run,
  output logic [15:0]                        dpram_len,
  output logic [CHAN_IDX_W-1:0]              chan_index,
  output logic [P_CNT_WIDTH-1:0]             evt_cnt,
  output logic                               err_timeout
);

  localparam int unsigned WT_W = $clog2(P_HDR_WT_CNT + 1);

  fsm_t                              state, state_nxt;
  logic [WT_W-1:0]                   wait_cnt;
  logic [N_CHANNELS*P_HDR_WIDTH-1:0]  hdr_q;
  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_q;
  logic [P_HDR_WIDTH-1:0]            hdr_mux;
  logic [P_DATA_WIDTH-1:0]           wvb_mux;
  logic [CHAN_IDX_W-1:0]             grant;
  logic                              grant_valid;
  logic                              start, evt_done, to_hit;

  rr_arbiter #(.N(N_CHANNELS)) u_arb (
    .req   (chan_mask & ~hdr_empty),
    .last  (chan_index),
    .grant (grant),
    .valid (grant_valid)
  );

  n_channel_mux #(.N_INPUTS(N_CHANNELS), .W(P_HDR_WIDTH), .SEL_W(CHAN_IDX_W)) u_hdr_mux (
    .data (hdr_q),
    .sel  (chan_index),
    .out  (hdr_mux)
  );

  n_channel_mux #(.N_INPUTS(N_CHANNELS), .W(P_DATA_WIDTH), .SEL_W(CHAN_IDX_W)) u_wvb_mux (
    .data (wvb_q),
    .sel  (chan_index),
    .out  (wvb_mux)
  );

  assign wvb_rdreq  = rd_wvb_rdreq  ? (N_CHANNELS'(1) << chan_index) : '0;
  assign wvb_rddone = rd_wvb_rddone ? (N_CHANNELS'(1) << chan_index) : '0;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    evt_done  = 1'b0;
    rd_req    = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_valid && !dpram_busy && !rd_ack) begin
          start     = 1'b1;
          state_nxt = S_HDR_WAIT;
        end
      end
      S_HDR_WAIT: begin
        if (wait_cnt == WT_W'(P_HDR_WT_CNT - 1)) state_nxt = S_RD_CTRL_REQ;
      end
      S_RD_CTRL_REQ: begin
        rd_req = 1'b1;
        if (rd_ack) state_nxt = S_DPRAM_RUN;
      end
      S_DPRAM_RUN: begin
        if (!dpram_busy) state_nxt = S_DPRAM_BUSY;
      end
      S_DPRAM_BUSY: begin
        if (dpram_busy) state_nxt = S_DPRAM_DONE;
      end
      S_DPRAM_DONE: begin
        if (!dpram_busy) begin
          if (dpram_mode && rd_more) begin
            if (!rd_ack) state_nxt = S_RD_CTRL_REQ;
          end else begin
            evt_done  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A watchdog expiry abandons the event without counting it.
    if (to_hit) begin
      state_nxt = S_IDLE;
      evt_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      hdr_q       <= '0;
      wvb_q       <= '0;
      rd_hdr_data <= '0;
      rd_wvb_data <= '0;
      hdr_rdreq   <= '0;
      dpram_run   <= 1'b0;
      dpram_len   <= '0;
      chan_index  <= '0;
      evt_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      hdr_q       <= hdr_data;
      wvb_q       <= wvb_data;
      rd_hdr_data <= hdr_mux;
      rd_wvb_data <= wvb_mux;
      hdr_rdreq   <= '0;
      dpram_run   <= 1'b0;
      if (start) begin
        chan_index <= grant;
        hdr_rdreq  <= N_CHANNELS'(1) << grant;
        wait_cnt   <= '0;
      end
      if (state == S_HDR_WAIT) wait_cnt <= wait_cnt + WT_W'(1);
      if (state == S_RD_CTRL_REQ && rd_ack) dpram_len <= rd_len;
      if (state == S_DPRAM_RUN && !dpram_busy) dpram_run <= 1'b1;
      if (evt_done) evt_cnt <= evt_cnt + P_CNT_WIDTH'(1);
    end
  end

`ifdef WVB_RDR_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        in_wait;

  assign in_wait = (state == S_DPRAM_BUSY) || (state == S_DPRAM_DONE);
  assign to_hit  = in_wait && (to_cnt == 32'(P_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      to_cnt <= (in_wait && !to_hit) ? to_cnt + 32'd1 : '0;
      if (to_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wvb_reader_arb.sv
// Self-checking bench for wvb_reader_arb (4 channels) against a rotating-priority reference model.
module tb_wvb_reader_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned HW = 80;
  localparam int unsigned DW = 85;
  localparam int unsigned WT = 3;
  localparam int unsigned CW = 32;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [N-1:0]    chan_mask, hdr_empty;
  logic [N*HW-1:0] hdr_data;
  logic [N*DW-1:0] wvb_data;
  logic [N-1:0]    hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic            rd_req, rd_ack, rd_more;
  logic [15:0]     rd_len;
  logic            rd_wvb_rdreq, rd_wvb_rddone;
  logic [HW-1:0]   rd_hdr_data;
  logic [DW-1:0]   rd_wvb_data;
  logic            dpram_busy, dpram_mode, dpram_run;
  logic [15:0]     dpram_len;
  logic [4:0]      chan_index;
  logic [CW-1:0]   evt_cnt;
  logic            err_timeout;

  int              checks = 0;
  int              errors = 0;
  int unsigned     last_g = 0;
  logic [CW-1:0]   exp_evt = '0;
  logic [HW-1:0]   hdr_w [N];
  logic [DW-1:0]   wvb_w [N];

  always #5 clk = ~clk;

  wvb_reader_arb #(
    .N_CHANNELS(N), .P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW),
    .P_HDR_WT_CNT(WT), .P_CNT_WIDTH(CW), .P_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .chan_mask(chan_mask), .hdr_empty(hdr_empty),
    .hdr_data(hdr_data), .wvb_data(wvb_data), .hdr_rdreq(hdr_rdreq),
    .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_more(rd_more), .rd_len(rd_len), .rd_wvb_rdreq(rd_wvb_rdreq),
    .rd_wvb_rddone(rd_wvb_rddone), .rd_hdr_data(rd_hdr_data), .rd_wvb_data(rd_wvb_data),
    .dpram_busy(dpram_busy), .dpram_mode(dpram_mode), .dpram_run(dpram_run),
    .dpram_len(dpram_len), .chan_index(chan_index), .evt_cnt(evt_cnt),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: walk channels last+1, last+2, ... modulo N; 'last' itself comes last.
  function automatic int next_grant(input int unsigned last, input logic [N-1:0] elig);
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned c = (last + k) % N;
      if (elig[c]) return int'(c);
    end
    return -1;
  endfunction

  task automatic load_words();
    for (int i = 0; i < N; i++) begin
      hdr_w[i] = HW'({$urandom(), $urandom(), $urandom()});
      wvb_w[i] = DW'({$urandom(), $urandom(), $urandom()});
      hdr_data[i*HW +: HW] = hdr_w[i];
      wvb_data[i*DW +: DW] = wvb_w[i];
    end
  endtask

  task automatic run_event(input int ch, input int nd, input bit abort,
                           input logic [15:0] l0, input logic [15:0] l1);
    logic [N-1:0] oh;
    logic [15:0]  l;
    bit           seen;
    bit           done_strb;
    int           n;
    oh = '0;
    oh[ch] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      if (hdr_rdreq != '0) seen = 1'b1;
    end
    chk("hdr_rdreq_seen", seen, 1);
    if (!seen) return;
    chk("hdr_rdreq_onehot", hdr_rdreq, oh);
    chk("chan_index_grant", chan_index, ch);
    hdr_empty[ch] = 1'b1;
    tick();
    chk("hdr_rdreq_pulse", hdr_rdreq, 0);
    n = 1;
    while (!rd_req && n < 12) begin
      tick();
      n++;
    end
    chk("hdr_wait_cycles", n, WT);
    chk("rd_hdr_data", rd_hdr_data, hdr_w[ch]);
    chk("rd_wvb_data", rd_wvb_data, wvb_w[ch]);
    for (int k = 0; k < nd; k++) begin
      l = (k == 0) ? l0 : l1;
      repeat ($urandom_range(0, 3)) tick();
      chk("rd_req_hold", rd_req, 1);
      rd_ack  = 1'b1;
      rd_len  = l;
      rd_more = (k < nd - 1) || (!dpram_mode && ($urandom_range(0, 1) == 1));
      tick();
      rd_ack = 1'b0;
      rd_len = 16'($urandom());
      chk("rd_req_drop", rd_req, 0);
      chk("dpram_len", dpram_len, l);
      if ($urandom_range(0, 1) == 1) begin
        dpram_busy = 1'b1;
        tick();
        tick();
        chk("dpram_run_held_off", dpram_run, 0);
        dpram_busy = 1'b0;
      end
      tick();
      chk("dpram_run_pulse", dpram_run, 1);
      dpram_busy = 1'b1;
      tick();
      chk("dpram_run_single", dpram_run, 0);
      done_strb = (k == nd - 1);
      rd_wvb_rdreq  = 1'b1;
      rd_wvb_rddone = done_strb;
      #1;
      chk("wvb_rdreq_demux", wvb_rdreq, oh);
      chk("wvb_rddone_demux", wvb_rddone, done_strb ? oh : '0);
      rd_wvb_rdreq  = 1'b0;
      rd_wvb_rddone = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      if (abort) begin
        en = 1'b0;
        tick();
        chk("abort_hdr_rdreq", hdr_rdreq, 0);
        chk("abort_rd_req", rd_req, 0);
        chk("abort_dpram_run", dpram_run, 0);
        chk("abort_dpram_len", dpram_len, 0);
        chk("abort_chan_index", chan_index, 0);
        chk("abort_evt_cnt", evt_cnt, 0);
        chk("abort_rd_hdr_data", rd_hdr_data, 0);
        chk("abort_rd_wvb_data", rd_wvb_data, 0);
        dpram_busy = 1'b0;
        rd_more    = 1'b0;
        en         = 1'b1;
        exp_evt    = '0;
        last_g     = 0;
        return;
      end
      dpram_busy = 1'b0;
      tick();
      if (k < nd - 1) begin
        chk("next_dpram_rd_req", rd_req, 1);
      end else begin
        exp_evt = exp_evt + 1'b1;
        chk("evt_cnt", evt_cnt, exp_evt);
        chk("rd_req_after_event", rd_req, 0);
      end
    end
    rd_more = 1'b0;
    last_g  = ch;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  g;
    bit  seen;
    logic [N-1:0] elig;
    rst = 1'b1; en = 1'b1;
    chan_mask = '1; hdr_empty = '1;
    rd_ack = 1'b0; rd_more = 1'b0; rd_len = '0;
    rd_wvb_rdreq = 1'b0; rd_wvb_rddone = 1'b0;
    dpram_busy = 1'b0; dpram_mode = 1'b0;
    load_words();
    repeat (3) tick();
    chk("reset_hdr_rdreq", hdr_rdreq, 0);
    chk("reset_rd_req", rd_req, 0);
    chk("reset_dpram_run", dpram_run, 0);
    chk("reset_chan_index", chan_index, 0);
    chk("reset_evt_cnt", evt_cnt, 0);
    chk("reset_rd_hdr_data", rd_hdr_data, 0);
    chk("reset_err_timeout", err_timeout, 0);
    rst = 1'b0;

    // Single non-empty channel.
    hdr_empty = 4'b1011;
    g = next_grant(last_g, chan_mask & ~hdr_empty);
    run_event(g, 1, 1'b0, 16'($urandom()), 16'h0);

    // Put last grant on ch1, then ch0/ch1/ch3 pending: rotation order follows.
    hdr_empty = 4'b1101;
    g = next_grant(last_g, chan_mask & ~hdr_empty);
    run_event(g, 1, 1'b0, 16'($urandom()), 16'h0);
    hdr_empty = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      g = next_grant(last_g, chan_mask & ~hdr_empty);
      run_event(g, 1, 1'b0, 16'($urandom()), 16'h0);
    end

    // Masked channel never granted.
    chan_mask = 4'b1101;
    hdr_empty = 4'b1101;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hdr_rdreq != '0 || rd_req) seen = 1'b1;
    end
    chk("masked_no_grant", seen, 0);
    chk("masked_chan_index", chan_index, last_g);
    hdr_empty = '1;
    chan_mask = '1;

    // rd_ack or dpram_busy high in idle blocks a grant.
    for (int b = 0; b < 2; b++) begin
      hdr_empty  = 4'b0111;
      rd_ack     = (b == 0);
      dpram_busy = (b == 1);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (hdr_rdreq != '0) seen = 1'b1;
      end
      chk("idle_blocked", seen, 0);
      rd_ack = 1'b0;
      dpram_busy = 1'b0;
      g = next_grant(last_g, chan_mask & ~hdr_empty);
      run_event(g, 1, 1'b0, 16'($urandom()), 16'h0);
    end

    // Multi-DPRAM event.
    dpram_mode = 1'b1;
    hdr_empty  = 4'b1110;
    g = next_grant(last_g, chan_mask & ~hdr_empty);
    run_event(g, 2, 1'b0, 16'h0040, 16'h0012);
    dpram_mode = 1'b0;

    // Enable dropped while waiting for DPRAM completion.
    hdr_empty = 4'b1011;
    g = next_grant(last_g, chan_mask & ~hdr_empty);
    run_event(g, 1, 1'b1, 16'($urandom()), 16'h0);

    // Randomized events.
    for (int it = 0; it < 30; it++) begin
      load_words();
      chan_mask  = N'($urandom());
      hdr_empty  = N'($urandom());
      dpram_mode = 1'($urandom());
      elig = chan_mask & ~hdr_empty;
      if (elig == '0) begin
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
          tick();
          if (hdr_rdreq != '0) seen = 1'b1;
        end
        chk("rand_no_elig", seen, 0);
      end else begin
        g = next_grant(last_g, elig);
        run_event(g, dpram_mode ? int'($urandom_range(1, 2)) : 1, 1'b0,
                  16'($urandom()), 16'($urandom()));
      end
      hdr_empty = '1;
    end
    chk("final_err_timeout", err_timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
